program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 The block SHALL have parameter WORD_W, default 32, instruction word width (fixed multiple of 8).
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 The block SHALL have port start  input  1  request to begin a load; sampled in IDLE only.
REQ-006 The block SHALL have port word_count  input  ADDR_W  words to load, captured at start; 0 means 2^ADDR_W.
REQ-007 The block SHALL have port byte_in  input  8  serial program byte.
REQ-008 The block SHALL have port byte_valid  input  1  byte_in holds a valid byte.
REQ-009 The block SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 The block SHALL have port im_wren  output  1  instruction-memory write strobe.
REQ-011 The block SHALL have port im_address  output  ADDR_W  instruction-memory write address.
REQ-012 The block SHALL have port im_data  output  WORD_W  instruction-memory write data.
REQ-013 The block SHALL have port cpu_enable  output  1  processor pipeline enable; low while loading.
REQ-014 The block SHALL have port cpu_hold  output  1  processor held in reset while high.
REQ-015 The block SHALL have port busy, done, error  output  1 each  load active, one-cycle completion pulse, checksum failure.

Function
REQ-016 The FSM SHALL have states IDLE, RECV, WRITE, CHECK, DONE.
REQ-017 IDLE SHALL go to RECV on start=1 and capture word_count, clear address counter, byte counter, checksum and error.
REQ-018 A byte SHALL be accepted only on a rising edge with byte_valid=1 and byte_ready=1. byte_ready SHALL be 1 in RECV and CHECK only.
REQ-019 Bytes SHALL be packed big-endian: first accepted byte goes to [WORD_W-1:WORD_W-8].
REQ-020 Acceptance of the WORD_W/8-th byte SHALL move the FSM to WRITE.
REQ-021 WRITE SHALL last exactly one cycle with im_wren=1, im_address=current counter, im_data=packed word, then increment the address counter modulo 2^ADDR_W.
REQ-022 After WRITE, the FSM SHALL return to RECV if words remain. Otherwise it SHALL go to CHECK (macro defined) or DONE.
REQ-023 DONE SHALL last one cycle with done=1, then go to IDLE. error SHALL hold its value until the next start or reset.
REQ-024 busy SHALL be 1 in every state except IDLE. cpu_hold SHALL equal busy. cpu_enable SHALL equal ~busy.
REQ-025 start SHALL be ignored outside IDLE. byte_valid SHALL be ignored while byte_ready=0 (no byte lost, no byte consumed).
REQ-026 With word_count=0, exactly 2^ADDR_W words SHALL be written to addresses 0..2^ADDR_W-1, ending without address wrap.
REQ-027 im_data and im_address SHALL be don't-care when im_wren=0, but SHALL be registered (no combinational path from byte_in).

Reset
REQ-028 On rst=1 the FSM SHALL enter IDLE immediately, including mid-load. Any partial word SHALL be discarded.
REQ-029 Reset values SHALL be: byte_ready=0, im_wren=0, im_address=0, im_data=0, busy=0, done=0, error=0, cpu_hold=0, cpu_enable=1.

Configuration
REQ-030 With LOADER_CHECKSUM_EN defined, the block SHALL XOR all accepted program bytes. CHECK SHALL accept one further byte and set error=1 if it differs from the running XOR, then go to DONE.
REQ-031 Without LOADER_CHECKSUM_EN, CHECK SHALL be unreachable, no checksum byte SHALL be consumed, and error SHALL be tied to 0.

Structure
REQ-032 Shared package loader_pkg SHALL hold the state enumeration, BYTES_PER_WORD constant and default widths.
REQ-033 A sub-module word_packer SHALL hold the byte shift register and byte counter, with a word_full output.

Verification
REQ-034 Reset with word_count=2, start, bytes 20 01 00 05 8C 02 00 00 -> im_wren pulses at addr 0 data 0x20010005, addr 1 data 0x8C020000, then done pulse, busy=0.
REQ-035 Same load with byte_valid toggled 1/0 every cycle -> identical writes; no byte accepted during WRITE.
REQ-036 word_count=0 with 1024 bytes -> 256 writes at addresses 0..255, done once, address counter back at 0.
REQ-037 rst asserted after 3 bytes of word 1 -> next cycle IDLE, cpu_enable=1, no further im_wren. A fresh start then loads from address 0.
REQ-038 LOADER_CHECKSUM_EN, one word 01 02 03 04, checksum byte 04 -> error=0. Checksum byte 05 -> error=1 at done and held.
REQ-039 start pulsed during RECV -> ignored. word_count changed mid-load -> write count unchanged.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and default sizes for the serial program loader.
package loader_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_WORD_W = 32;
  localparam int BYTES_PER_WORD = DEFAULT_WORD_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/word_packer.sv
// Byte-to-word shift register with byte counter.
// The first byte accepted ends up in the most significant byte of the word.
module word_packer
  import loader_pkg::*;
#(
  parameter int BYTES = BYTES_PER_WORD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 accept,
  input  logic [7:0]           byte_in,
  output logic [8*BYTES-1:0]   word,
  output logic                 word_full
);

  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

  logic [CNT_W-1:0]     count;
  logic [8*BYTES-1:0]   shifted;

  // word_full flags the accept of the final byte, so the FSM can leave RECV on that edge
  assign word_full = accept && (count == LAST);

  generate
    if (BYTES == 1) begin : g_single
      assign shifted = byte_in;
    end else begin : g_multi
      assign shifted = {word[8*BYTES-9:0], byte_in};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word  <= '0;
      count <= '0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (accept) begin
        count <= word_full ? '0 : count + 1'b1;
      end
      if (accept) begin
        word <= shifted;
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Serial program loader: packs bytes into words and writes them to instruction memory.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int WORD_W = DEFAULT_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              im_wren,
  output logic [ADDR_W-1:0] im_address,
  output logic [WORD_W-1:0] im_data,
  output logic              cpu_enable,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int BPW = WORD_W / 8;

  state_t state, next_state;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   words_left;
  logic              accept;
  logic              word_full;
  logic              last_word;
  logic              load_start;

  assign byte_ready = (state == RECV) || (state == CHECK);
  assign accept     = byte_valid && byte_ready;
  assign load_start = (state == IDLE) && start;
  assign last_word  = (words_left == (ADDR_W+1)'(1));

  word_packer #(.BYTES(BPW)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (load_start),
    .accept    (accept && (state == RECV)),
    .byte_in   (byte_in),
    .word      (im_data),
    .word_full (word_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = RECV;
      RECV:  if (word_full) next_state = WRITE;
      WRITE: begin
        if (!last_word) begin
          next_state = RECV;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = DONE;
`endif
        end
      end
      CHECK: if (accept) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // words_left is one bit wider so a zero word_count can stand for 2^ADDR_W words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      words_left <= '0;
    end else if (load_start) begin
      addr       <= '0;
      words_left <= (word_count == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, word_count};
    end else if (state == WRITE) begin
      addr       <= addr + 1'b1;
      words_left <= words_left - 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
      err  <= 1'b0;
    end else if (load_start) begin
      csum <= '0;
      err  <= 1'b0;
    end else if (accept && (state == RECV)) begin
      csum <= csum ^ byte_in;
    end else if (accept && (state == CHECK)) begin
      err  <= (byte_in != csum);
    end
  end

  assign error = err;
`else
  assign error = 1'b0;
`endif

  assign im_wren    = (state == WRITE);
  assign im_address = addr;
  assign done       = (state == DONE);
  assign busy       = (state != IDLE);
  assign cpu_hold   = busy;
  assign cpu_enable = ~busy;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus queues expected writes/done pulses,
// a negedge monitor pops and compares them. Checksum cases run when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

  localparam int ADDR_W = 8;
  localparam int WORD_W = 32;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    bit          is_done;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] word_count;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              im_wren;
  logic [ADDR_W-1:0] im_address;
  logic [WORD_W-1:0] im_data;
  logic              cpu_enable;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;

  program_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .im_wren    (im_wren),
    .im_address (im_address),
    .im_data    (im_data),
    .cpu_enable (cpu_enable),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic expectWrite(input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.is_done = 1'b0;
    e.addr    = a;
    e.data    = d;
    e.err     = 1'b0;
    sb.push_back(e);
  endtask

  task automatic expectDone(input logic err);
    exp_t e;
    e.is_done = 1'b1;
    e.addr    = '0;
    e.data    = '0;
    e.err     = err;
    sb.push_back(e);
  endtask

  function automatic byte_q_t withSum(input byte_q_t q);
    byte_q_t    r;
    logic [7:0] s;
    r = q;
    s = 8'h00;
    foreach (q[i]) s = s ^ q[i];
`ifdef LOADER_CHECKSUM_EN
    r.push_back(s);
`endif
    return r;
  endfunction

  // Monitor: every write strobe or done pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && (im_wren || done)) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_event", {62'b0, im_wren, done}, 64'h0);
      end else begin
        mon_e = sb.pop_front();
        if (im_wren) begin
          checkOutput("write_kind", 64'(mon_e.is_done), 64'h0);
          checkOutput("write_addr", 64'(im_address), 64'(mon_e.addr));
          checkOutput("write_data", 64'(im_data), 64'(mon_e.data));
          checkOutput("ready_in_write", 64'(byte_ready), 64'h0);
        end else begin
          checkOutput("done_kind", 64'(mon_e.is_done), 64'h1);
          checkOutput("done_error", 64'(error), 64'(mon_e.err));
          checkOutput("done_busy", 64'(busy), 64'h1);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] wc, input byte_q_t bytes,
                               input bit toggle, input bit glitch);
    int idx;
    int cyc;
    bit phase;
    bit acc;
    @(negedge clk);
    word_count = wc;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx   = 0;
    cyc   = 0;
    phase = 1'b1;
    while (idx < bytes.size() && cyc < 5000) begin
      byte_in    = bytes[idx];
      byte_valid = toggle ? phase : 1'b1;
      phase      = ~phase;
      if (glitch && idx == 2) begin
        start      = 1'b1;
        word_count = wc + 8'd3;
      end else begin
        start = 1'b0;
      end
      acc = byte_valid && byte_ready;
      @(posedge clk);
      cyc++;
      if (acc) idx++;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    if (cyc >= 5000) checkOutput("byte_timeout", 64'(idx), 64'(bytes.size()));
    cyc = 0;
    while (busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("return_idle", 64'(busy), 64'h0);
    checkOutput("cpu_enable_idle", 64'(cpu_enable), 64'h1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    byte_q_t b;
    logic [7:0] k;

    rst        = 1'b1;
    start      = 1'b0;
    word_count = '0;
    byte_in    = '0;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_byte_ready", 64'(byte_ready), 64'h0);
    checkOutput("rst_im_wren", 64'(im_wren), 64'h0);
    checkOutput("rst_im_address", 64'(im_address), 64'h0);
    checkOutput("rst_im_data", 64'(im_data), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_done", 64'(done), 64'h0);
    checkOutput("rst_error", 64'(error), 64'h0);
    checkOutput("rst_cpu_hold", 64'(cpu_hold), 64'h0);
    checkOutput("rst_cpu_enable", 64'(cpu_enable), 64'h1);
    rst = 1'b0;

    $display("[TB] two-word load");
    b = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h00};
    expectWrite(8'd0, 32'h20010005);
    expectWrite(8'd1, 32'h8C020000);
    expectDone(1'b0);
    applyStimulus(8'd2, withSum(b), 1'b0, 1'b0);

    $display("[TB] two-word load, gapped valid, start/word_count glitch");
    expectWrite(8'd0, 32'h20010005);
    expectWrite(8'd1, 32'h8C020000);
    expectDone(1'b0);
    applyStimulus(8'd2, withSum(b), 1'b1, 1'b1);

    $display("[TB] reset mid-word");
    @(negedge clk);
    word_count = 8'd2;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      byte_in    = 8'hE0 + 8'(i);
      byte_valid = 1'b1;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'h0);
    checkOutput("midrst_cpu_enable", 64'(cpu_enable), 64'h1);
    checkOutput("midrst_im_wren", 64'(im_wren), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    expectWrite(8'd0, 32'h11223344);
    expectDone(1'b0);
    applyStimulus(8'd1, withSum(b), 1'b0, 1'b0);

    $display("[TB] full 256-word load");
    b = {};
    for (int i = 0; i < 1024; i++) b.push_back(8'(i));
    for (int i = 0; i < 256; i++) begin
      k = 8'(4 * i);
      expectWrite(8'(i), {k, k + 8'd1, k + 8'd2, k + 8'd3});
    end
    expectDone(1'b0);
    applyStimulus(8'd0, withSum(b), 1'b0, 1'b0);
    checkOutput("addr_back_to_zero", 64'(im_address), 64'h0);

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] checksum good/bad");
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    expectWrite(8'd0, 32'h01020304);
    expectDone(1'b0);
    applyStimulus(8'd1, b, 1'b0, 1'b0);
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    expectWrite(8'd0, 32'h01020304);
    expectDone(1'b1);
    applyStimulus(8'd1, b, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("error_held", 64'(error), 64'h1);
`else
    checkOutput("error_tied_low", 64'(error), 64'h0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
